rx_dcm_ctrl: RTL and testbench
==============================

RX_DCM_CTRL -- requirements
Module: rx_dcm_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 8, DCM reset pulse length in rxclk_in cycles (min 3).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, cycles to wait for lock per attempt.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, cycles of continuous lock before release.
REQ-004 SHALL have parameter MAX_RETRY, default 7, lock attempts after the first before declaring failure.
REQ-005 SHALL have port rxclk_in  input  1  free-running reference clock, sole clock of the block.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port dcm_locked  input  1  raw DCM LOCKED, asynchronous to rxclk_in.
REQ-008 SHALL have port relock_req  input  1  single-cycle request to force a relock.
REQ-009 SHALL have port dcm_rst  output  1  DCM RST drive.
REQ-010 SHALL have port rx_rst_n  output  1  rx datapath reset, active-low.
REQ-011 SHALL have port clk_ok  output  1  high only while clocks are stable and released.
REQ-012 SHALL have port lock_fail  output  1  retries exhausted.
REQ-013 SHALL have port retry_cnt  output  3  attempts used since the last RUN or relock_req.

Function
REQ-014 SHALL synchronise dcm_locked through 2 flops into locked_s; all decisions use locked_s only.
REQ-015 SHALL implement states RESET_DCM, WAIT_LOCK, STABLE, RUN, FAIL; all outputs Moore-decoded from the state register.
REQ-016 RESET_DCM: dcm_rst=1; after exactly RST_CYCLES cycles in the state -> WAIT_LOCK.
REQ-017 WAIT_LOCK: dcm_rst=0; locked_s=1 -> STABLE; timeout after LOCK_TIMEOUT cycles -> FAIL if retry_cnt==MAX_RETRY, else retry_cnt+1 and -> RESET_DCM.
REQ-018 STABLE: locked_s=0 -> RESET_DCM, retry_cnt unchanged; STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN.
REQ-019 RUN: rx_rst_n=1, clk_ok=1, retry_cnt cleared on entry; locked_s=0 -> RESET_DCM.
REQ-020 FAIL: lock_fail=1, dcm_rst=1; leaves FAIL only on relock_req.
REQ-021 rx_rst_n SHALL be 0 and clk_ok SHALL be 0 in every state except RUN.
REQ-022 relock_req in any state SHALL -> RESET_DCM with retry_cnt cleared; it overrides same-cycle lock or timeout events.
REQ-023 A single shared cycle counter SHALL be cleared on every state transition; its width SHALL be derived from the largest of the three cycle parameters.
REQ-024 retry_cnt SHALL never exceed MAX_RETRY; MAX_RETRY SHALL fit in 3 bits.

Reset
REQ-025 reset_n low SHALL asynchronously force state RESET_DCM, counter 0, retry_cnt 0, synchroniser flops 0.
REQ-026 During and directly after reset: dcm_rst=1, rx_rst_n=0, clk_ok=0, lock_fail=0.
REQ-027 Reset mid-operation (any state) SHALL restart the full sequence from RESET_DCM.

Configuration
REQ-028 Macro RX_DCM_LOSS_CNT_EN defined: SHALL add output lock_loss_cnt, 8 bits, saturating at 255, incremented on each RUN->RESET_DCM transition caused by locked_s=0, not by relock_req, cleared only by reset.
REQ-029 Macro RX_DCM_LOSS_CNT_EN undefined: the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package rx_clk_pkg SHALL hold the state enumeration and the retry_cnt width constant.
REQ-031 The 2-flop synchroniser SHALL be a sub-module named rx_sync2; no other sub-modules.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=16, MAX_RETRY=2)
REQ-032 Reset release, dcm_locked high 10 cycles after dcm_rst falls -> dcm_rst high exactly 4 cycles; rx_rst_n and clk_ok rise 16 cycles after locked_s goes high.
REQ-033 dcm_locked held low -> three 4-cycle dcm_rst pulses spaced 32 cycles; retry_cnt steps 0,1,2; then lock_fail=1 and dcm_rst=1; a relock_req pulse clears retry_cnt and lock_fail.
REQ-034 In STABLE, dcm_locked low for 1 cycle at count 10 -> return to RESET_DCM, rx_rst_n stays 0, retry_cnt unchanged.
REQ-035 In RUN, drop dcm_locked -> rx_rst_n falls 3 cycles later (2 sync + 1 state); with RX_DCM_LOSS_CNT_EN, lock_loss_cnt increments by 1.
REQ-036 relock_req in the same cycle as locked_s rises in WAIT_LOCK -> next state RESET_DCM, retry_cnt 0; reset_n pulsed low during RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rx_clk_pkg.sv
// rx_clk_pkg: shared types and constants for the rx clock / DCM lock controller.
//   dcm_state_e : controller state encoding
//   RETRY_W     : width of the retry_cnt output
//   max3()      : helper that sizes the shared cycle counter
package rx_clk_pkg;

    localparam int RETRY_W = 3;

    typedef enum logic [2:0] {
        RESET_DCM = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } dcm_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rx_sync2.sv
// rx_sync2: two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
module rx_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_dcm_ctrl.sv
// rx_dcm_ctrl: sequences DCM reset, waits for lock with timeout and retry,
// qualifies lock stability and then releases the rx datapath.
//   rxclk_in      : free-running reference clock (only clock)
//   reset_n       : asynchronous active-low reset
//   dcm_locked    : raw DCM LOCKED, asynchronous
//   relock_req    : one-cycle request to restart the lock sequence
//   dcm_rst       : DCM RST drive
//   rx_rst_n      : rx datapath reset, active-low
//   clk_ok        : clocks stable and datapath released
//   lock_fail     : lock attempts exhausted
//   retry_cnt     : attempts used since last RUN or relock_req
//   lock_loss_cnt : (only with RX_DCM_LOSS_CNT_EN) saturating count of
//                   lock losses seen while in RUN
//
// Optional build macro: RX_DCM_LOSS_CNT_EN adds lock_loss_cnt.
//
// state     | meaning
// ----------+-------------------------------------------------------
// RESET_DCM | DCM held in reset for RST_CYCLES cycles
// WAIT_LOCK | DCM released, waiting up to LOCK_TIMEOUT for lock
// STABLE    | lock seen, waiting for it to stay up STABLE_CYCLES
// RUN       | clocks good, rx datapath released
// FAIL      | retries exhausted, DCM held in reset until relock_req
module rx_dcm_ctrl
    import rx_clk_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic               rxclk_in,
    input  logic               reset_n,
    input  logic               dcm_locked,
    input  logic               relock_req,
    output logic               dcm_rst,
    output logic               rx_rst_n,
    output logic               clk_ok,
    output logic               lock_fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef RX_DCM_LOSS_CNT_EN
   ,output logic [7:0]         lock_loss_cnt
`endif
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees locked_s counts as the first
    // stable cycle, so STABLE itself only needs STABLE_CYCLES-1 cycles.
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic               locked_s;
    dcm_state_e         state;
    dcm_state_e         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               restart;

    rx_sync2 u_sync_locked (
        .clk   (rxclk_in),
        .rst_n (reset_n),
        .d     (dcm_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        unique case (state)
            RESET_DCM: begin
                if (cnt == RST_TC) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == LOCK_TC) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt = RESET_DCM;
                        retry_nxt = retry_cnt + RETRY_W'(1);
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = RESET_DCM;
                end else if (cnt == STABLE_TC) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                if (!locked_s) state_nxt = RESET_DCM;
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = RESET_DCM;
            end
        endcase
        // relock wins over any lock/timeout event in the same cycle
        if (relock_req) begin
            state_nxt = RESET_DCM;
            retry_nxt = '0;
        end
    end

    // relock_req while already in RESET_DCM restarts the pulse as well
    assign restart = (state_nxt != state) || relock_req;

    // Outputs are registered from state_nxt so they always equal a pure
    // decode of the state register, with no extra cycle of lag.
    always_ff @(posedge rxclk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET_DCM;
            cnt       <= '0;
            retry_cnt <= '0;
            dcm_rst   <= 1'b1;
            rx_rst_n  <= 1'b0;
            clk_ok    <= 1'b0;
            lock_fail <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            cnt       <= restart ? '0 : cnt + CNT_W'(1);
            dcm_rst   <= (state_nxt == RESET_DCM) || (state_nxt == FAIL);
            rx_rst_n  <= (state_nxt == RUN);
            clk_ok    <= (state_nxt == RUN);
            lock_fail <= (state_nxt == FAIL);
        end
    end

`ifdef RX_DCM_LOSS_CNT_EN
    always_ff @(posedge rxclk_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_cnt <= '0;
        end else if ((state == RUN) && !locked_s && !relock_req &&
                     (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`else
    // Loss counter not built in this configuration.
`endif

endmodule

// File: tb/tb_rx_dcm_ctrl.sv
// tb_rx_dcm_ctrl: directed bench for rx_dcm_ctrl with an output-change
// scoreboard. Stimulus pushes the expected output vector and cycle of each
// output change; the monitor pops one entry per observed change.
module tb_rx_dcm_ctrl;

    logic       rxclk_in;
    logic       reset_n;
    logic       dcm_locked;
    logic       relock_req;
    logic       dcm_rst;
    logic       rx_rst_n;
    logic       clk_ok;
    logic       lock_fail;
    logic [2:0] retry_cnt;
`ifdef RX_DCM_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    typedef struct {
        int         c;
        logic       dr;
        logic       rr;
        logic       ok;
        logic       lf;
        logic [2:0] rc;
    } ev_t;

    ev_t exp_q[$];

    rx_dcm_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (16),
        .MAX_RETRY     (2)
    ) dut (
        .rxclk_in      (rxclk_in),
        .reset_n       (reset_n),
        .dcm_locked    (dcm_locked),
        .relock_req    (relock_req),
        .dcm_rst       (dcm_rst),
        .rx_rst_n      (rx_rst_n),
        .clk_ok        (clk_ok),
        .lock_fail     (lock_fail),
        .retry_cnt     (retry_cnt)
`ifdef RX_DCM_LOSS_CNT_EN
       ,.lock_loss_cnt (lock_loss_cnt)
`endif
    );

    initial rxclk_in = 1'b0;
    always #5 rxclk_in = ~rxclk_in;

    // cyc = rising edges since reset was last released
    always @(posedge rxclk_in or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    logic [6:0] cur;
    logic [6:0] prev = 'x;

    always @(negedge rxclk_in) begin
        ev_t e;
        cur = {dcm_rst, rx_rst_n, clk_ok, lock_fail, retry_cnt};
        if (cur !== prev) begin
            prev = cur;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got dr=%b rr=%b ok=%b lf=%b rc=%0d, none required",
                         cyc, dcm_rst, rx_rst_n, clk_ok, lock_fail, retry_cnt);
            end else begin
                e = exp_q.pop_front();
                if ((e.c != cyc) || (cur !== {e.dr, e.rr, e.ok, e.lf, e.rc})) begin
                    n_bad++;
                    $display("FAIL event cyc=%0d got dr=%b rr=%b ok=%b lf=%b rc=%0d, required cyc=%0d dr=%b rr=%b ok=%b lf=%b rc=%0d",
                             cyc, dcm_rst, rx_rst_n, clk_ok, lock_fail, retry_cnt,
                             e.c, e.dr, e.rr, e.ok, e.lf, e.rc);
                end
            end
        end
    end

    task automatic ev(input int c, input bit dr, input bit rr, input bit ok,
                      input bit lf, input int rc);
        ev_t e;
        e.c  = c;
        e.dr = dr;
        e.rr = rr;
        e.ok = ok;
        e.lf = lf;
        e.rc = 3'(rc);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 5000) begin
            @(negedge rxclk_in);
            n++;
        end
        if (cyc != c) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc got=%0d required=%0d", cyc, c);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        dcm_locked = 1'b0;
        relock_req = 1'b0;

        // power-on reset and first lock
        ev(0, 1, 0, 0, 0, 0);
        ev(4, 0, 0, 0, 0, 0);
        ev(32, 0, 1, 1, 0, 0);
        repeat (3) @(negedge rxclk_in);
        reset_n = 1'b1;
        wait_cyc(14);
        dcm_locked = 1'b1;

        // lock lost in RUN, then a timeout with the DCM still unlocked
        ev(43, 1, 0, 0, 0, 0);
        ev(47, 0, 0, 0, 0, 0);
        ev(79, 1, 0, 0, 0, 1);
        ev(83, 0, 0, 0, 0, 1);
        wait_cyc(40);
        dcm_locked = 1'b0;
        wait_cyc(50);
`ifdef RX_DCM_LOSS_CNT_EN
        chk("loss_cnt_first", int'(lock_loss_cnt), 1);
`endif

        // one-cycle lock glitch mid-STABLE keeps retry_cnt, then lock to RUN
        ev(101, 1, 0, 0, 0, 1);
        ev(105, 0, 0, 0, 0, 1);
        ev(121, 0, 1, 1, 0, 0);
        wait_cyc(86);
        dcm_locked = 1'b1;
        wait_cyc(98);
        dcm_locked = 1'b0;
        wait_cyc(99);
        dcm_locked = 1'b1;

        // relock from RUN, timeout, then relock colliding with lock rise
        ev(126, 1, 0, 0, 0, 0);
        ev(130, 0, 0, 0, 0, 0);
        ev(162, 1, 0, 0, 0, 1);
        ev(166, 0, 0, 0, 0, 1);
        ev(172, 1, 0, 0, 0, 0);
        ev(176, 0, 0, 0, 0, 0);
        ev(192, 0, 1, 1, 0, 0);
        wait_cyc(125);
        dcm_locked = 1'b0;
        relock_req = 1'b1;
        wait_cyc(126);
        relock_req = 1'b0;
        wait_cyc(169);
        dcm_locked = 1'b1;
        wait_cyc(171);
        relock_req = 1'b1;
        wait_cyc(172);
        relock_req = 1'b0;

        // retries exhausted -> FAIL, cleared by relock_req
        ev(198, 1, 0, 0, 0, 0);
        ev(202, 0, 0, 0, 0, 0);
        ev(234, 1, 0, 0, 0, 1);
        ev(238, 0, 0, 0, 0, 1);
        ev(270, 1, 0, 0, 0, 2);
        ev(274, 0, 0, 0, 0, 2);
        ev(306, 1, 0, 0, 1, 2);
        ev(316, 1, 0, 0, 0, 0);
        ev(320, 0, 0, 0, 0, 0);
        ev(340, 0, 1, 1, 0, 0);
        wait_cyc(195);
        dcm_locked = 1'b0;
        wait_cyc(312);
        chk("fail_hold_lock_fail", int'(lock_fail), 1);
        chk("fail_hold_dcm_rst", int'(dcm_rst), 1);
        wait_cyc(315);
        relock_req = 1'b1;
        wait_cyc(316);
        relock_req = 1'b0;
`ifdef RX_DCM_LOSS_CNT_EN
        chk("loss_cnt_second", int'(lock_loss_cnt), 2);
`endif
        wait_cyc(322);
        dcm_locked = 1'b1;

        // asynchronous reset while in RUN
        wait_cyc(345);
        ev(0, 1, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_dcm_rst", int'(dcm_rst), 1);
        chk("async_rx_rst_n", int'(rx_rst_n), 0);
        chk("async_clk_ok", int'(clk_ok), 0);
        chk("async_lock_fail", int'(lock_fail), 0);
        chk("async_retry_cnt", int'(retry_cnt), 0);
`ifdef RX_DCM_LOSS_CNT_EN
        chk("async_loss_cnt", int'(lock_loss_cnt), 0);
`endif
        repeat (3) @(negedge rxclk_in);
        ev(4, 0, 0, 0, 0, 0);
        ev(20, 0, 1, 1, 0, 0);
        reset_n = 1'b1;
        wait_cyc(25);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
